grid_bank_server: RTL and testbench

- Responder side of the freemachine memory interface.
- Owns the grid bank (BANK_DEPTH rows x GRID_VEC_ALIGN_N bits, accessed in TX_DATA_WIDTH chunks).
- Arbitrates round-robin among N_CLIENTS freemachine initiators and serves one chunk read or write per transaction with a one-cycle ack pulse.
- A host port loads the grid before run and reads it back after done.

---
 rtl/aoc4_pkg.sv | 32 +++
 rtl/grid_bank_server_rr_arbiter.sv | 46 ++++
 rtl/grid_bank_server.sv | 184 ++++++++++++++++++
 tb/tb_grid_bank_server.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc4_pkg.sv
// Shared constants and types for the grid bank.
// A grid row is GRID_VEC_ALIGN_N bits wide and is accessed in TX_DATA_WIDTH chunks.
// Row and column addresses carry one spare bit, so that requesters can name
// out-of-range locations (for example the row just past the last row).
package aoc4_pkg;

  localparam int TX_DATA_WIDTH    = 8;
  localparam int GRID_VEC_ALIGN_N = 16;
  localparam int BANK_DEPTH       = 4;
  localparam int BANK_ADDR_WIDTH  = $clog2(BANK_DEPTH) + 1;
  localparam int COL_ADDR_WIDTH   = $clog2(GRID_VEC_ALIGN_N) + 1;
  localparam int N_CHUNKS         = GRID_VEC_ALIGN_N / TX_DATA_WIDTH;
  localparam int TX_SHIFT         = $clog2(TX_DATA_WIDTH);
  localparam int CHUNK_IDX_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int ROW_IDX_W        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} bank_state_e;

  typedef struct packed {
    logic                       rd;
    logic                       wr;
    logic [BANK_ADDR_WIDTH-1:0] row;
    logic [COL_ADDR_WIDTH-1:0]  col;
    logic [TX_DATA_WIDTH-1:0]   wdata;
  } bank_req_t;

  // The column address is already a bit offset into the row.
  function automatic logic [COL_ADDR_WIDTH-1:0] VEC_OFFSET(input logic [COL_ADDR_WIDTH-1:0] col);
    return col;
  endfunction

endpackage

// File: rtl/grid_bank_server_rr_arbiter.sv
// Round-robin arbiter.
// Ports: clock/reset (sync, active-high); req[N] requests; advance moves the
// pointer to the current winner + 1; grant is one-hot; index is the winner.
// Priority is searched from the pointer upward, wrapping at N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   slot;
    logic found;
    grant = '0;
    index = '0;
    found = 1'b0;
    slot  = 0;
    for (int off = 0; off < N; off++) begin
      slot = (int'(ptr_q) + off) % N;
      if (!found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        index       = IW'(slot);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(index) == N - 1) ? '0 : IW'(int'(index) + 1);
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/grid_bank_server.sv
// Grid bank responder. Serves one chunk read or write per transaction to
// N_CLIENTS initiators plus a host port, with a one-cycle ack pulse.
// Ports: clock/reset (sync, active-high); per-client rd/wr level requests with
// row/col/wdata; ack_out per client; rdata_out shared; host_* request/ack/rdata;
// busy_out high in ACCESS/RESP; err_count_out (saturating) counts out-of-range
// accesses; txn_count_out (wrapping) counts completed transactions.
// Slot N_CLIENTS is the host. HOST_PRIO=1 lets the host preempt the clients.
module grid_bank_server
  import aoc4_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int HOST_PRIO = 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [N_CLIENTS-1:0]                      rd_en_in,
  input  logic [N_CLIENTS-1:0]                      wr_en_in,
  input  logic [N_CLIENTS-1:0][BANK_ADDR_WIDTH-1:0] row_addr_in,
  input  logic [N_CLIENTS-1:0][COL_ADDR_WIDTH-1:0]  col_addr_in,
  input  logic [N_CLIENTS-1:0][TX_DATA_WIDTH-1:0]   wdata_in,
  output logic [N_CLIENTS-1:0]                      ack_out,
  output logic [TX_DATA_WIDTH-1:0]                  rdata_out,
  input  logic                                      host_rd_en,
  input  logic                                      host_wr_en,
  input  logic [BANK_ADDR_WIDTH-1:0]                host_row,
  input  logic [COL_ADDR_WIDTH-1:0]                 host_col,
  input  logic [TX_DATA_WIDTH-1:0]                  host_wdata,
  output logic                                      host_ack,
  output logic [TX_DATA_WIDTH-1:0]                  host_rdata,
  output logic                                      busy_out,
  output logic [15:0]                               err_count_out,
  output logic [31:0]                               txn_count_out
);

  localparam int SLOTS  = N_CLIENTS + 1;
  localparam int WIW    = $clog2(SLOTS);
  localparam int ARB_N  = (HOST_PRIO != 0) ? N_CLIENTS : SLOTS;
  localparam int ARB_IW = (ARB_N > 1) ? $clog2(ARB_N) : 1;

  bank_state_e state_q, state_d;
  logic [WIW-1:0] win_q, win_d;
  bank_req_t cap_q, cap_d;
  logic [TX_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0] err_q, err_d;
  logic [31:0] txn_q, txn_d;
  logic prev_resp_q, prev_resp_d;
  logic [BANK_DEPTH-1:0][N_CHUNKS-1:0][TX_DATA_WIDTH-1:0] mem_q, mem_d;

  bank_req_t [SLOTS-1:0] req;
  logic [SLOTS-1:0] pending, last_mask, eligible, slot_ack;

  // Write wins over read of the same requester.
  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      req[i].wr    = wr_en_in[i];
      req[i].rd    = rd_en_in[i] & ~wr_en_in[i];
      req[i].row   = row_addr_in[i];
      req[i].col   = col_addr_in[i];
      req[i].wdata = wdata_in[i];
    end
    req[N_CLIENTS].wr    = host_wr_en;
    req[N_CLIENTS].rd    = host_rd_en & ~host_wr_en;
    req[N_CLIENTS].row   = host_row;
    req[N_CLIENTS].col   = host_col;
    req[N_CLIENTS].wdata = host_wdata;
  end

  // The requester acked last cycle has not yet seen its ack, so its request
  // lines are stale for one IDLE cycle and must not start a new transaction.
  always_comb begin
    last_mask = '0;
    if (prev_resp_q) last_mask[win_q] = 1'b1;
    for (int i = 0; i < SLOTS; i++) pending[i] = req[i].rd | req[i].wr;
    eligible = pending & ~last_mask;
  end

  logic [ARB_N-1:0]  arb_req, arb_grant;
  logic [ARB_IW-1:0] arb_idx;
  logic              host_go, any_go, arb_adv;
  logic [WIW-1:0]    win_sel;

  if (HOST_PRIO != 0) begin : g_host_prio
    assign host_go = eligible[N_CLIENTS];
    assign arb_req = eligible[N_CLIENTS-1:0];
  end else begin : g_host_rr
    assign host_go = 1'b0;
    assign arb_req = eligible;
  end

  assign any_go  = host_go | (|arb_grant);
  assign win_sel = host_go ? WIW'(N_CLIENTS) : WIW'(arb_idx);
  // A preempting host grant leaves the client pointer where it was.
  assign arb_adv = (state_q == ST_IDLE) && !host_go && (|arb_grant);

  rr_arbiter #(.N(ARB_N)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_adv),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  logic                   in_range;
  logic [ROW_IDX_W-1:0]   row_idx;
  logic [CHUNK_IDX_W-1:0] chunk_idx;

  assign in_range  = (cap_q.row < BANK_ADDR_WIDTH'(BANK_DEPTH))
                  && (cap_q.col < COL_ADDR_WIDTH'(GRID_VEC_ALIGN_N))
                  && (cap_q.col[TX_SHIFT-1:0] == '0);
  assign row_idx   = ROW_IDX_W'(cap_q.row);
  assign chunk_idx = CHUNK_IDX_W'(VEC_OFFSET(cap_q.col) >> TX_SHIFT);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_go) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture in IDLE, access in ACCESS (result and counters land in RESP).
  always_comb begin
    win_d       = win_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    txn_d       = txn_q;
    mem_d       = mem_q;
    prev_resp_d = (state_q == ST_RESP);
    if (state_q == ST_IDLE && any_go) begin
      win_d = win_sel;
      cap_d = req[win_sel];
    end
    if (state_q == ST_ACCESS) begin
      // Writes return the old chunk; out-of-range accesses return zero.
      rdata_d = (in_range && (cap_q.rd || cap_q.wr)) ? mem_q[row_idx][chunk_idx] : '0;
      if (in_range && cap_q.wr) mem_d[row_idx][chunk_idx] = cap_q.wdata;
      if (!in_range && err_q != 16'hFFFF) err_d = err_q + 16'd1;
      txn_d = txn_q + 32'd1;
    end
  end

  // The bank itself is not reset, and a write in ACCESS commits even if reset
  // is asserted on that edge.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      txn_q       <= '0;
      prev_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      txn_q       <= txn_d;
      prev_resp_q <= prev_resp_d;
    end
  end

  // Outputs.
  always_comb begin
    slot_ack = '0;
    if (state_q == ST_RESP) slot_ack[win_q] = 1'b1;
  end

  assign ack_out       = slot_ack[N_CLIENTS-1:0];
  assign host_ack      = slot_ack[N_CLIENTS];
  assign busy_out      = (state_q == ST_ACCESS) || (state_q == ST_RESP);
  assign rdata_out     = rdata_q;
  assign host_rdata    = rdata_q;
  assign err_count_out = err_q;
  assign txn_count_out = txn_q;

endmodule

// File: tb/tb_grid_bank_server.sv
// Directed bench for grid_bank_server (N_CLIENTS=2, HOST_PRIO=1; slot 2 = host).
module tb_grid_bank_server;
  import aoc4_pkg::*;

  logic                                clock;
  logic                                reset;
  logic [1:0]                          rd_en_in, wr_en_in;
  logic [1:0][BANK_ADDR_WIDTH-1:0]     row_addr_in;
  logic [1:0][COL_ADDR_WIDTH-1:0]      col_addr_in;
  logic [1:0][TX_DATA_WIDTH-1:0]       wdata_in;
  logic [1:0]                          ack_out;
  logic [TX_DATA_WIDTH-1:0]            rdata_out;
  logic                                host_rd_en, host_wr_en;
  logic [BANK_ADDR_WIDTH-1:0]          host_row;
  logic [COL_ADDR_WIDTH-1:0]           host_col;
  logic [TX_DATA_WIDTH-1:0]            host_wdata;
  logic                                host_ack;
  logic [TX_DATA_WIDTH-1:0]            host_rdata;
  logic                                busy_out;
  logic [15:0]                         err_count_out;
  logic [31:0]                         txn_count_out;
  logic [2:0]                          acks;

  int checks = 0;
  int errors = 0;

  grid_bank_server #(.N_CLIENTS(2), .HOST_PRIO(1)) dut (
    .clock(clock), .reset(reset),
    .rd_en_in(rd_en_in), .wr_en_in(wr_en_in),
    .row_addr_in(row_addr_in), .col_addr_in(col_addr_in), .wdata_in(wdata_in),
    .ack_out(ack_out), .rdata_out(rdata_out),
    .host_rd_en(host_rd_en), .host_wr_en(host_wr_en), .host_row(host_row),
    .host_col(host_col), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .busy_out(busy_out), .err_count_out(err_count_out), .txn_count_out(txn_count_out)
  );

  assign acks = {host_ack, ack_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int                         slot;
    logic                       rd;
    logic                       wr;
    logic [BANK_ADDR_WIDTH-1:0] row;
    logic [COL_ADDR_WIDTH-1:0]  col;
    logic [7:0]                 wd;
    logic                       chk_rd;
    logic [7:0]                 exp_rd;
    logic [15:0]                exp_err;
    logic [31:0]                exp_txn;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int slot, input logic rd, input logic wr,
                         input logic [BANK_ADDR_WIDTH-1:0] row,
                         input logic [COL_ADDR_WIDTH-1:0] col, input logic [7:0] wd);
    if (slot == 2) begin
      host_rd_en = rd; host_wr_en = wr; host_row = row; host_col = col; host_wdata = wd;
    end else begin
      rd_en_in[slot] = rd; wr_en_in[slot] = wr;
      row_addr_in[slot] = row; col_addr_in[slot] = col; wdata_in[slot] = wd;
    end
  endtask

  // Issue one request from an idle bank; ack is expected two edges later.
  // Returns the data seen in the ack cycle and leaves two idle cycles behind.
  task automatic run_txn(input string name, input int slot, input logic rd, input logic wr,
                         input logic [BANK_ADDR_WIDTH-1:0] row,
                         input logic [COL_ADDR_WIDTH-1:0] col, input logic [7:0] wd,
                         output logic [7:0] got, output logic [7:0] got_host);
    int lat;
    bit seen;
    set_req(slot, rd, wr, row, col, wd);
    lat = 0;
    seen = 0;
    while (!seen && lat < 10) begin
      tick();
      lat++;
      if (acks != 3'b000) seen = 1;
    end
    chk({name, " ack latency"}, lat, 2);
    chk({name, " ack vector"}, {29'd0, acks}, 32'd1 << slot);
    got = rdata_out;
    got_host = host_rdata;
    set_req(slot, 1'b0, 1'b0, '0, '0, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] g, gh;
    int n, cyc, h_cyc, c_cyc;
    int who [6];
    int at [6];
    logic [7:0] first_rd;

    rd_en_in = '0; wr_en_in = '0; row_addr_in = '0; col_addr_in = '0; wdata_in = '0;
    host_rd_en = 0; host_wr_en = 0; host_row = '0; host_col = '0; host_wdata = '0;
    reset = 1'b1;

    vec[0]  = '{2, 1'b0, 1'b1, 3'd2, 5'd8,  8'hA5, 1'b1, 8'h28, 16'd0, 32'd9};
    vec[1]  = '{2, 1'b1, 1'b0, 3'd2, 5'd8,  8'h00, 1'b1, 8'hA5, 16'd0, 32'd10};
    vec[2]  = '{0, 1'b1, 1'b1, 3'd1, 5'd0,  8'h3C, 1'b1, 8'h10, 16'd0, 32'd11};
    vec[3]  = '{1, 1'b1, 1'b0, 3'd1, 5'd0,  8'h00, 1'b1, 8'h3C, 16'd0, 32'd12};
    vec[4]  = '{1, 1'b1, 1'b0, 3'd4, 5'd0,  8'h00, 1'b1, 8'h00, 16'd1, 32'd13};
    vec[5]  = '{1, 1'b0, 1'b1, 3'd1, 5'd4,  8'hFF, 1'b0, 8'h00, 16'd2, 32'd14};
    vec[6]  = '{0, 1'b1, 1'b0, 3'd1, 5'd0,  8'h00, 1'b1, 8'h3C, 16'd2, 32'd15};
    vec[7]  = '{0, 1'b1, 1'b0, 3'd1, 5'd8,  8'h00, 1'b1, 8'h18, 16'd2, 32'd16};
    vec[8]  = '{1, 1'b1, 1'b0, 3'd0, 5'd16, 8'h00, 1'b1, 8'h00, 16'd3, 32'd17};
    vec[9]  = '{0, 1'b0, 1'b1, 3'd0, 5'd8,  8'h77, 1'b1, 8'h08, 16'd3, 32'd18};
    vec[10] = '{2, 1'b1, 1'b0, 3'd0, 5'd8,  8'h00, 1'b1, 8'h77, 16'd3, 32'd19};
    vec[11] = '{1, 1'b1, 1'b0, 3'd3, 5'd8,  8'h00, 1'b1, 8'h38, 16'd3, 32'd20};

    repeat (3) tick();
    chk("reset ack_out", {30'd0, ack_out}, 0);
    chk("reset host_ack", {31'd0, host_ack}, 0);
    chk("reset busy", {31'd0, busy_out}, 0);
    chk("reset rdata", {24'd0, rdata_out}, 0);
    chk("reset host_rdata", {24'd0, host_rdata}, 0);
    chk("reset err", {16'd0, err_count_out}, 0);
    chk("reset txn", txn_count_out, 0);
    reset = 1'b0;

    // Preload every chunk through the host: value = row*16 + col.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c += 8)
        run_txn("init", 2, 1'b0, 1'b1, 3'(r), 5'(c), 8'(r * 16 + c), g, gh);
    chk("init txn", txn_count_out, 8);

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("v%0d", i), vec[i].slot, vec[i].rd, vec[i].wr, vec[i].row,
              vec[i].col, vec[i].wd, g, gh);
      if (vec[i].chk_rd) begin
        chk($sformatf("v%0d rdata", i), {24'd0, g}, {24'd0, vec[i].exp_rd});
        chk($sformatf("v%0d host_rdata", i), {24'd0, gh}, {24'd0, vec[i].exp_rd});
      end
      chk($sformatf("v%0d err", i), {16'd0, err_count_out}, {16'd0, vec[i].exp_err});
      chk($sformatf("v%0d txn", i), txn_count_out, vec[i].exp_txn);
    end

    // Round-robin from a fresh pointer: both clients read (0,0) continuously.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 3'd0, 5'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 3'd0, 5'd0, 8'h00);
    n = 0; cyc = 0; first_rd = 8'hEE;
    while (n < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (ack_out != 2'b00) begin
        if (n == 0) first_rd = rdata_out;
        who[n] = int'(ack_out);
        at[n] = cyc;
        n++;
        if (n == 6) begin
          set_req(0, 1'b0, 1'b0, '0, '0, 8'h00);
          set_req(1, 1'b0, 1'b0, '0, '0, 8'h00);
        end
      end
    end
    chk("rr grant count", n, 6);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("rr ack%0d owner", k), who[k], (k % 2 == 0) ? 1 : 2);
      chk($sformatf("rr ack%0d spacing", k), (k == 0) ? at[0] : at[k] - at[k-1], (k == 0) ? 2 : 3);
    end
    chk("rr rdata", {24'd0, first_rd}, 0);
    tick(); tick();
    chk("rr txn", txn_count_out, 6);

    // Host grant with pointer at 0 must leave it at 0: client 0 wins next.
    run_txn("host alone", 2, 1'b1, 1'b0, 3'd3, 5'd8, 8'h00, g, gh);
    chk("host alone rdata", {24'd0, gh}, 8'h38);
    set_req(0, 1'b1, 1'b0, 3'd0, 5'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 3'd0, 5'd0, 8'h00);
    cyc = 0;
    while (ack_out == 2'b00 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("ptr hold first winner", {30'd0, ack_out}, 2'b01);
    chk("ptr hold latency", cyc, 2);
    set_req(0, 1'b0, 1'b0, '0, '0, 8'h00);
    set_req(1, 1'b0, 1'b0, '0, '0, 8'h00);
    tick(); tick();

    // Host and client 0 request in the same IDLE cycle.
    set_req(2, 1'b1, 1'b0, 3'd0, 5'd8, 8'h00);
    set_req(0, 1'b1, 1'b0, 3'd2, 5'd8, 8'h00);
    h_cyc = 0; c_cyc = 0; cyc = 0;
    while ((h_cyc == 0 || c_cyc == 0) && cyc < 20) begin
      tick();
      cyc++;
      if (host_ack) begin
        h_cyc = cyc;
        chk("host first rdata", {24'd0, host_rdata}, 8'h77);
        set_req(2, 1'b0, 1'b0, '0, '0, 8'h00);
      end
      if (ack_out[0]) begin
        c_cyc = cyc;
        chk("client after host rdata", {24'd0, rdata_out}, 8'hA5);
        set_req(0, 1'b0, 1'b0, '0, '0, 8'h00);
      end
    end
    chk("host first ack cycle", h_cyc, 2);
    chk("client after host ack cycle", c_cyc, 5);
    tick(); tick();

    // Reset during ACCESS of a client-0 write: no ack, but the write commits.
    set_req(0, 1'b0, 1'b1, 3'd3, 5'd0, 8'h11);
    tick();
    chk("access busy", {31'd0, busy_out}, 1);
    reset = 1'b1;
    tick();
    chk("post reset busy", {31'd0, busy_out}, 0);
    chk("post reset ack", {29'd0, acks}, 0);
    set_req(0, 1'b0, 1'b0, '0, '0, 8'h00);
    reset = 1'b0;
    n = 0;
    repeat (3) begin
      tick();
      if (acks != 3'b000) n++;
    end
    chk("no late ack", n, 0);
    chk("post reset txn", txn_count_out, 0);
    run_txn("readback", 1, 1'b1, 1'b0, 3'd3, 5'd0, 8'h00, g, gh);
    chk("readback rdata", {24'd0, g}, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
